// File: rtl/halfband_tdm_unpack.sv
`default_nettype none
// ============================================================================
//  Module      : halfband_tdm_unpack
//  Description : Unpacks the halfband decimator's free-running TDM output.
//                The first NCH slots of every PERIOD-slot frame carry one
//                sample per channel; the remaining slots are idle and are
//                discarded. Kept samples pass through a one-word stage
//                register into a first-word-fall-through FIFO. They are
//                presented as tagged {och, od} words on a valid/ready
//                interface.
//  Option      : `define HB_UNPACK_SAT_EN enables a left shift by GAIN_SHIFT
//                with signed 24-bit saturation in the stage register.
//                Without it, samples pass bit-exact.
//  Ports       : c        clock
//                rst_n    asynchronous active-low reset
//                sync     marks the cycle in which id carries channel 0
//                id       24-bit signed TDM sample
//                od       24-bit signed output sample (registered)
//                och      channel tag of od (registered)
//                ovalid   od/och valid; held until accepted
//                oready   consumer accepts od/och when ovalid & oready
//                level    FIFO occupancy (stage register excluded)
//                overflow sticky flag: a sample was dropped on a full FIFO
//                clr_ovf  clears overflow (a same-cycle drop wins)
//  Revision    : 1.0  initial release
// ============================================================================
module halfband_tdm_unpack #(
  parameter int NCH        = 4,
  parameter int PERIOD     = 8,
  parameter int DEPTH      = 16,
  parameter int GAIN_SHIFT = 0
) (
  input  logic                     c,
  input  logic                     rst_n,
  input  logic                     sync,
  input  logic [23:0]              id,
  output logic [23:0]              od,
  output logic [$clog2(NCH)-1:0]   och,
  output logic                     ovalid,
  input  logic                     oready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int c_CHW = $clog2(NCH);
  localparam int c_CW  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int c_AW  = $clog2(DEPTH);
  localparam int c_LW  = c_AW + 1;

  localparam logic [c_LW-1:0] c_FULL = c_LW'(DEPTH);
  localparam logic [c_LW-1:0] c_ONE  = c_LW'(1);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(PERIOD - 1);

  // GAIN_SHIFT is only consumed by the saturating path; values outside 0..7
  // are reserved and leave this marker scope in the elaborated hierarchy.
  if ((GAIN_SHIFT < 0) || (GAIN_SHIFT > 7)) begin : g_gain_shift_reserved
  end

  // --------------------------------------------------------------------------
  // Slot tracking
  // --------------------------------------------------------------------------
  logic [c_CW-1:0] r_cnt;
  logic [c_CW-1:0] w_slot;
  logic [c_CW-1:0] w_cnt_nxt;
  logic            r_locked;
  logic            w_cap;

  // sync forces slot 0 in its own cycle, so a mid-frame sync realigns at once.
  assign w_slot    = sync ? '0 : r_cnt;
  assign w_cnt_nxt = (w_slot == c_LAST) ? '0 : w_slot + 1'b1;
  assign w_cap     = (r_locked | sync) && (32'(w_slot) < 32'(NCH));

  // --------------------------------------------------------------------------
  // Sample conditioning
  // --------------------------------------------------------------------------
  logic [23:0] w_dat;

`ifdef HB_UNPACK_SAT_EN
  logic signed [31:0] w_ext;
  logic signed [31:0] w_shl;

  // 24 + 7 bits of shifted magnitude fit in 32 bits, so the shift never wraps.
  assign w_ext = 32'(signed'(id));
  assign w_shl = w_ext <<< GAIN_SHIFT;

  always_comb begin
    w_dat = w_shl[23:0];
    if (w_shl > 32'sd8388607) begin
      w_dat = 24'h7F_FFFF;
    end else if (w_shl < -32'sd8388608) begin
      w_dat = 24'h80_0000;
    end
  end
`else
  assign w_dat = id;
`endif

  // --------------------------------------------------------------------------
  // Stage-1 register
  // --------------------------------------------------------------------------
  logic             r_s1_vld;
  logic [c_CHW-1:0] r_s1_ch;
  logic [23:0]      r_s1_dat;

  // --------------------------------------------------------------------------
  // FIFO storage and control
  // --------------------------------------------------------------------------
  // The word at r_rp is the one shown on od/och; level counts it, so the
  // output register is a registered copy of the FIFO head, not extra space.
  logic [23:0]      r_mem_d [DEPTH];
  logic [c_CHW-1:0] r_mem_c [DEPTH];
  logic [c_AW-1:0]  r_wp;
  logic [c_AW-1:0]  r_rp;
  logic [c_AW-1:0]  w_rp_nxt1;
  logic [c_LW-1:0]  r_level;
  logic [c_LW-1:0]  w_level_nxt;

  logic             r_ovalid;
  logic [23:0]      r_od;
  logic [c_CHW-1:0] r_och;
  logic             r_ovf;

  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_load;
  logic [23:0]      w_head_d;
  logic [c_CHW-1:0] w_head_c;

  assign w_pop     = r_ovalid & oready;
  // A full FIFO still takes the word when the head leaves in the same cycle.
  assign w_push    = r_s1_vld & ((r_level != c_FULL) | w_pop);
  assign w_drop    = r_s1_vld & ~w_push;
  assign w_rp_nxt1 = r_rp + 1'b1;

  // Next head selection. With two or more words stored, the successor is
  // already in memory; with one or zero, only a same-cycle push can supply
  // it, and that comes straight from the stage register.
  always_comb begin
    w_level_nxt = r_level;
    w_load      = 1'b0;
    w_head_d    = r_s1_dat;
    w_head_c    = r_s1_ch;

    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + 1'b1;
      2'b01:   w_level_nxt = r_level - 1'b1;
      default: w_level_nxt = r_level;
    endcase

    if (w_pop) begin
      if (r_level > c_ONE) begin
        w_load   = 1'b1;
        w_head_d = r_mem_d[w_rp_nxt1];
        w_head_c = r_mem_c[w_rp_nxt1];
      end else if (w_push) begin
        w_load = 1'b1;
      end
    end else if ((r_level == '0) && w_push) begin
      w_load = 1'b1;
    end
  end

  // Storage array: no reset, only written at the write pointer.
  always_ff @(posedge c) begin
    if (w_push) begin
      r_mem_d[r_wp] <= r_s1_dat;
      r_mem_c[r_wp] <= r_s1_ch;
    end
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_locked <= 1'b0;
      r_s1_vld <= 1'b0;
      r_s1_ch  <= '0;
      r_s1_dat <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
      r_level  <= '0;
      r_ovalid <= 1'b0;
      r_od     <= '0;
      r_och    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (sync) begin
        r_locked <= 1'b1;
      end

      r_s1_vld <= w_cap;
      if (w_cap) begin
        r_s1_ch  <= w_slot[c_CHW-1:0];
        r_s1_dat <= w_dat;
      end

      if (w_push) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= w_rp_nxt1;
      end
      r_level <= w_level_nxt;

      // od/och keep their last value once the FIFO empties.
      if (w_load) begin
        r_od  <= w_head_d;
        r_och <= w_head_c;
      end
      r_ovalid <= (w_level_nxt != '0);

      // A drop in the clearing cycle keeps the flag set.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign od       = r_od;
  assign och      = r_och;
  assign ovalid   = r_ovalid;
  assign level    = r_level;
  assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_halfband_tdm_unpack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_halfband_tdm_unpack
//  Description : Self-checking bench for halfband_tdm_unpack (NCH=4,
//                PERIOD=8, DEPTH=16, GAIN_SHIFT=4). A reference model
//                queues expected words at capture and retires them on
//                handshake; a vector table covers the first locked frames.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_halfband_tdm_unpack;

  localparam int NCH    = 4;
  localparam int PERIOD = 8;
  localparam int DEPTH  = 16;
  localparam int GS     = 4;

  logic        c = 1'b0;
  logic        rst_n = 1'b0;
  logic        sync = 1'b0;
  logic [23:0] id = '0;
  logic        oready = 1'b0;
  logic        clr_ovf = 1'b0;
  logic [23:0] od;
  logic [1:0]  och;
  logic        ovalid;
  logic [4:0]  level;
  logic        overflow;

  halfband_tdm_unpack #(
    .NCH(NCH), .PERIOD(PERIOD), .DEPTH(DEPTH), .GAIN_SHIFT(GS)
  ) dut (
    .c(c), .rst_n(rst_n), .sync(sync), .id(id), .od(od), .och(och),
    .ovalid(ovalid), .oready(oready), .level(level), .overflow(overflow),
    .clr_ovf(clr_ovf)
  );

  always #5 c = ~c;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]  ch;
    logic [23:0] d;
  } ent_t;

  typedef struct {
    logic        s;
    logic [23:0] d;
    logic        rdy;
    logic        ev;
    logic [23:0] eod;
    logic [1:0]  ech;
    logic [4:0]  elev;
  } vec_t;

  ent_t        q[$];
  int          m_cnt;
  bit          m_lock, m_s1v, m_ovf;
  ent_t        m_s1;
  logic [23:0] m_od;
  logic [1:0]  m_och;
  vec_t        tbl[10];

  function automatic logic [23:0] xform(input logic [23:0] d);
`ifdef HB_UNPACK_SAT_EN
    longint v;
    v = longint'(signed'(d)) * longint'(1 << GS);
    if (v > 64'sd8388607) return 24'h7F_FFFF;
    if (v < -64'sd8388608) return 24'h80_0000;
    return v[23:0];
`else
    return d;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cnt  = 0;
    m_lock = 0;
    m_s1v  = 0;
    m_ovf  = 0;
    m_od   = '0;
    m_och  = '0;
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic cyc(input logic s, input logic [23:0] d, input logic rdy, input logic clr);
    int slot;
    bit pop, drop;
    sync = s; id = d; oready = rdy; clr_ovf = clr;
    pop  = (q.size() != 0) && rdy;
    drop = 0;
    if (pop) void'(q.pop_front());
    if (m_s1v) begin
      if (q.size() < DEPTH) q.push_back(m_s1);
      else drop = 1;
    end
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
    slot  = s ? 0 : m_cnt;
    m_s1v = (m_lock || s) && (slot < NCH);
    if (m_s1v) begin
      m_s1.ch = slot[1:0];
      m_s1.d  = xform(d);
    end
    m_cnt = (slot + 1) % PERIOD;
    if (s) m_lock = 1;
    if (q.size() != 0) begin
      m_od  = q[0].d;
      m_och = q[0].ch;
    end
    @(posedge c); #1;
    chk("sb_ovalid",   32'(ovalid),   32'(q.size() != 0));
    chk("sb_level",    32'(level),    32'(q.size()));
    chk("sb_od",       32'(od),       32'(m_od));
    chk("sb_och",      32'(och),      32'(m_och));
    chk("sb_overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic frame(input logic [23:0] base, input logic rdy);
    for (int s = 0; s < PERIOD; s++) cyc(s == 0, base + 24'(s), rdy, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 10; k++) begin
      tbl[k].s   = (k % PERIOD) == 0;
      tbl[k].d   = 24'h100 + 24'(k % PERIOD);
      tbl[k].rdy = 1'b1;
    end
    // {ovalid, od, och, level} after each row's clock edge
    tbl[0].ev = 0; tbl[0].eod = 24'h0;         tbl[0].ech = 0; tbl[0].elev = 0;
    tbl[1].ev = 1; tbl[1].eod = xform(24'h100); tbl[1].ech = 0; tbl[1].elev = 1;
    tbl[2].ev = 1; tbl[2].eod = xform(24'h101); tbl[2].ech = 1; tbl[2].elev = 1;
    tbl[3].ev = 1; tbl[3].eod = xform(24'h102); tbl[3].ech = 2; tbl[3].elev = 1;
    tbl[4].ev = 1; tbl[4].eod = xform(24'h103); tbl[4].ech = 3; tbl[4].elev = 1;
    tbl[5].ev = 0; tbl[5].eod = xform(24'h103); tbl[5].ech = 3; tbl[5].elev = 0;
    tbl[6].ev = 0; tbl[6].eod = xform(24'h103); tbl[6].ech = 3; tbl[6].elev = 0;
    tbl[7].ev = 0; tbl[7].eod = xform(24'h103); tbl[7].ech = 3; tbl[7].elev = 0;
    tbl[8].ev = 0; tbl[8].eod = xform(24'h103); tbl[8].ech = 3; tbl[8].elev = 0;
    tbl[9].ev = 1; tbl[9].eod = xform(24'h100); tbl[9].ech = 0; tbl[9].elev = 1;

    // Reset state
    model_reset();
    repeat (3) @(posedge c);
    #1;
    chk("rst_od", 32'(od), 32'h0);
    chk("rst_och", 32'(och), 32'h0);
    chk("rst_ovalid", 32'(ovalid), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    rst_n = 1'b1;

    // Unlocked: data without sync is never captured
    for (int i = 0; i < 20; i++) cyc(1'b0, 24'h200 + 24'(i), 1'b1, 1'b0);
    chk("unlocked_ovalid", 32'(ovalid), 32'h0);
    chk("unlocked_level", 32'(level), 32'h0);

    // Table: first locked frames, latency and idle-slot suppression
    for (int k = 0; k < 10; k++) begin
      cyc(tbl[k].s, tbl[k].d, tbl[k].rdy, 1'b0);
      chk($sformatf("tbl%0d_ovalid", k), 32'(ovalid), 32'(tbl[k].ev));
      chk($sformatf("tbl%0d_od", k), 32'(od), 32'(tbl[k].eod));
      chk($sformatf("tbl%0d_och", k), 32'(och), 32'(tbl[k].ech));
      chk($sformatf("tbl%0d_level", k), 32'(level), 32'(tbl[k].elev));
    end

    // Basic streaming
    for (int f = 0; f < 3; f++) frame(24'h100, 1'b1);

    // Backpressure: five frames stalled, sixth stalled with clr on a drop
    for (int f = 0; f < 5; f++) frame(24'h3000 + 24'(f * 16), 1'b0);
    for (int s = 0; s < PERIOD; s++) cyc(s == 0, 24'h3050 + 24'(s), 1'b0, s == 1);
    chk("bp_level_full", 32'(level), 32'd16);
    chk("bp_overflow", 32'(overflow), 32'h1);
    // Drain: frames 0..3 first, then the fresh frames
    for (int f = 6; f < 9; f++) frame(24'h3000 + 24'(f * 16), 1'b1);
    cyc(1'b0, 24'h0, 1'b1, 1'b1);
    chk("clr_alone", 32'(overflow), 32'h0);

    // Full FIFO with simultaneous push and pop
    frame(24'h4000, 1'b1);
    for (int f = 1; f < 5; f++) frame(24'h4000 + 24'(f * 16), 1'b0);
    cyc(1'b1, 24'h4050, 1'b0, 1'b0);
    cyc(1'b0, 24'h4051, 1'b1, 1'b0);
    chk("full_pushpop_level", 32'(level), 32'd16);
    chk("full_pushpop_ovf", 32'(overflow), 32'h0);
    for (int s = 2; s < PERIOD; s++) cyc(1'b0, 24'h4050 + 24'(s), 1'b1, 1'b0);
    for (int f = 0; f < 3; f++) frame(24'h4100, 1'b1);

    // Resync at slot 2
    cyc(1'b1, 24'h500, 1'b1, 1'b0);
    cyc(1'b0, 24'h501, 1'b1, 1'b0);
    cyc(1'b1, 24'h502, 1'b1, 1'b0);
    cyc(1'b0, 24'h503, 1'b1, 1'b0);
    chk("resync_och", 32'(och), 32'h0);
    chk("resync_od", 32'(od), 32'(xform(24'h502)));
    for (int s = 2; s < PERIOD; s++) cyc(1'b0, 24'h502 + 24'(s), 1'b1, 1'b0);

    // Data path boundaries
    cyc(1'b1, 24'h10_0000, 1'b1, 1'b0);
    cyc(1'b0, 24'hFF_FFFB, 1'b1, 1'b0);
`ifdef HB_UNPACK_SAT_EN
    chk("dat_pos", 32'(od), 32'h7F_FFFF);
`else
    chk("dat_pos", 32'(od), 32'h10_0000);
`endif
    cyc(1'b0, 24'h80_0000, 1'b1, 1'b0);
`ifdef HB_UNPACK_SAT_EN
    chk("dat_neg", 32'(od), 32'hFF_FFB0);
`else
    chk("dat_neg", 32'(od), 32'hFF_FFFB);
`endif
    cyc(1'b0, 24'h0, 1'b1, 1'b0);
    chk("dat_min", 32'(od), 32'h80_0000);
    for (int s = 4; s < PERIOD; s++) cyc(1'b0, 24'h0, 1'b1, 1'b0);

    // Reset mid-operation with five words held
    frame(24'h600, 1'b0);
    cyc(1'b1, 24'h610, 1'b0, 1'b0);
    cyc(1'b0, 24'h611, 1'b0, 1'b0);
    chk("pre_rst_level", 32'(level), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_od", 32'(od), 32'h0);
    chk("mid_rst_och", 32'(och), 32'h0);
    chk("mid_rst_ovalid", 32'(ovalid), 32'h0);
    chk("mid_rst_level", 32'(level), 32'h0);
    chk("mid_rst_overflow", 32'(overflow), 32'h0);
    @(posedge c); #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 12; i++) cyc(1'b0, 24'h700 + 24'(i), 1'b1, 1'b0);
    chk("post_rst_ovalid", 32'(ovalid), 32'h0);
    frame(24'h800, 1'b1);
    frame(24'h800, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/halfband_tdm_unpack.md
Name: halfband_tdm_unpack

Overview:
Downstream stage of the halfband decimator. Consumes the decimator's free-running TDM output word, one word per clock at NCH*OSR rate. Keeps the NCH valid output slots of each frame and discards the idle slots. Buffers the kept samples in a FIFO and presents them as tagged {channel, sample} words on a valid/ready interface for the next consumer (DDC back end or host capture).

Parameters:
NCH, 4, channels per TDM frame (power of 2, 2..16)
PERIOD, 8, clocks per output frame (>= NCH); slots 0..NCH-1 carry data, NCH..PERIOD-1 are idle
DEPTH, 16, FIFO depth in words (power of 2, >= 4)
GAIN_SHIFT, 0, left shift applied when HB_UNPACK_SAT_EN is defined (0..7)

Ports:
c  in  1  clock
rst_n  in  1  asynchronous active-low reset
sync  in  1  high in the cycle that id carries channel 0 of a frame
id  in  24  signed sample from the decimator
od  out  24  signed output sample
och  out  log2(NCH)  channel index of od
ovalid  out  1  od/och valid
oready  in  1  consumer accepts od/och when ovalid&oready
level  out  log2(DEPTH)+1  FIFO occupancy
overflow  out  1  sticky: a sample was dropped because the FIFO was full
clr_ovf  in  1  clears overflow

Behaviour:
- Reset (async assert, sync release): slot counter 0, locked=0, FIFO empty, od=0, och=0, ovalid=0, level=0, overflow=0.
- Slot tracking: effective slot = 0 when sync=1, else counter. Next counter = (effective slot+1) mod PERIOD. sync sets locked=1.
- A sync arriving mid-frame resynchronises immediately; the partial frame's already-captured samples stay in the FIFO.
- While locked=0, no samples are captured.
- Capture: when locked (or sync this cycle) and effective slot < NCH, register {slot, id} into a stage-1 register. Next cycle, write it to the FIFO.
- Latency: a sample on id in cycle t appears on od with ovalid=1 at cycle t+2 when the FIFO is empty (first-word-fall-through, registered outputs).
- Output order equals capture order: channel 0..NCH-1, frame after frame.
- FIFO write is accepted if level<DEPTH, or if a pop (ovalid&oready) occurs in the same cycle.
- Otherwise the word is dropped and overflow is set. Level is unchanged on a drop.
- Simultaneous push and pop: level unchanged, pointers both advance, wrap mod DEPTH.
- Empty with a push: ovalid rises next cycle. A pop of the last word with no push: ovalid falls next cycle, and od/och hold their last value.
- ovalid stays high and od/och stay stable until accepted (no retraction).
- clr_ovf clears overflow next cycle. A drop in the same cycle as clr_ovf wins (overflow stays 1).
- level = number of words in the FIFO, excluding the stage-1 register.
- No arithmetic on data unless the optional feature is enabled; id passes bit-exact.

Optional Feature:
- Macro: HB_UNPACK_SAT_EN.
- Defined: the stage-1 register holds sat24(id <<< GAIN_SHIFT), with signed saturation to +8388607 / -8388608. Latency is unchanged.
- Undefined: data passes bit-exact and GAIN_SHIFT is ignored.

Test Plan:
- Basic: NCH=4, PERIOD=8, sync every 8 cycles, id = 0x100+slot, oready=1 -> od sequence 0x100,0x101,0x102,0x103 repeating, och 0..3, first ovalid 2 cycles after the first sync, idle slots never emitted.
- Unlocked: 20 cycles of data with no sync after reset -> ovalid stays 0 and level=0. First sync then starts capture with och=0.
- Backpressure/overflow: oready=0 for 6 frames (24 captures, DEPTH=16) -> level saturates at 16 and overflow=1. With oready=1, the first 16 words drain in order (frames 0..3) and no later words appear before frame 6.
- Simultaneous full push/pop: FIFO full, oready=1 during a capture slot -> the word is accepted, level stays 16, overflow stays 0.
- Resync and clear: sync asserted at slot 2 of a frame -> the next capture is tagged och=0. clr_ovf together with a drop -> overflow remains 1; clr_ovf alone -> overflow=0 next cycle.
- Reset mid-operation: rst_n low while the FIFO holds 5 words -> outputs zero immediately. After release, locked=0 and no stale word appears. With HB_UNPACK_SAT_EN and GAIN_SHIFT=4: id=0x100000 -> od=0x7FFFFF; id=-5 -> od=-80.
